div_32: RTL
===========

DIV_32 -- requirements
Module: div_32

Interface
REQ-001 The block SHALL have exactly the following ports, listed with direction, width and meaning.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_start  input  1  request a division; sampled on the rising edge.
REQ-005 i_signed  input  1  1 = DIV/REM (two's complement), 0 = DIVU/REMU; sampled with i_start.
REQ-006 i_a  input  32  dividend; sampled with i_start.
REQ-007 i_b  input  32  divisor; sampled with i_start.
REQ-008 o_quot  output  32  quotient; held stable from the o_valid cycle until the next accepted start.
REQ-009 o_rem  output  32  remainder; held stable under the same rule as o_quot.
REQ-010 o_busy  output  1  high while in state CALC or FIX.
REQ-011 o_valid  output  1  one-cycle pulse; high only while in state DONE.

Function
REQ-012 The state machine SHALL have exactly four states: IDLE, CALC, FIX, DONE.
REQ-013 A start SHALL be accepted when i_start=1 at an edge where the state is IDLE or DONE; i_start in CALC or FIX SHALL be ignored.
REQ-014 On an accepted start the block SHALL register the operand magnitudes (absolute values when i_signed=1), the result signs, the mode, and a 5-bit iteration counter set to 0.
REQ-015 When i_b=0 on accept, the next state SHALL be DONE with o_quot=0xFFFFFFFF and o_rem=i_a.
REQ-016 When i_signed=1, i_a=0x80000000 and i_b=0xFFFFFFFF on accept, the next state SHALL be DONE with o_quot=0x80000000 and o_rem=0.
REQ-017 In all other accepted cases the next state SHALL be CALC.
REQ-018 CALC SHALL run one restoring iteration per cycle:
- form a 33-bit trial difference = {partial remainder, next dividend bit} minus {0, divisor}, using the sub_32-style a + ~b + 1 carry chain;
- carry-out 1: keep the difference and shift a quotient bit of 1;
- carry-out 0: restore (keep the undifferenced value) and shift a quotient bit of 0.
REQ-019 CALC SHALL last exactly 32 cycles, after which the counter wraps from 31 to 0 and the state moves to FIX.
REQ-020 FIX SHALL last one cycle, in which the block:
- negates the quotient if the dividend sign differs from the divisor sign (signed mode only);
- negates the remainder if the dividend is negative (signed mode only);
- registers both results into o_quot and o_rem;
- moves to DONE.
REQ-021 DONE SHALL last one cycle, then go to IDLE unless a new start is accepted.
REQ-022 Latency SHALL be fixed by path: for a start accepted at edge N,
- normal division: o_valid is high in the cycle after edge N+33;
- divide-by-zero or overflow: o_valid is high in the cycle after edge N.
REQ-023 The remainder SHALL take the sign of the dividend, and the quotient SHALL truncate toward zero, matching RV32M.
REQ-024 Changes on i_a, i_b or i_signed after accept SHALL NOT affect the operation in progress.

Reset
REQ-025 While rst_n=0, regardless of clk, the block SHALL force state=IDLE, counter=0, o_quot=0, o_rem=0, o_busy=0 and o_valid=0.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no o_valid pulse.
REQ-027 After reset deasserts, the first start SHALL be accepted at the first rising edge with i_start=1.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- Unsigned basic: i_signed=0, 100/7 -> o_quot=14, o_rem=2; o_valid one cycle after edge N+33; o_busy high for 33 cycles.
- Signed: -7/2 (0xFFFFFFF9/0x00000002) -> o_quot=0xFFFFFFFD, o_rem=0xFFFFFFFF. Signed 7/-2 -> o_quot=0xFFFFFFFD, o_rem=1.
- Divide by zero: i_a=0x12345678, i_b=0 in both modes -> o_quot=0xFFFFFFFF, o_rem=0x12345678; o_valid in the cycle after the accept edge; o_busy never high.
- Overflow: signed 0x80000000/0xFFFFFFFF -> o_quot=0x80000000, o_rem=0. The same operands unsigned -> o_quot=0, o_rem=0x80000000 via the normal 34-cycle path.
- Back-to-back and ignore:
  - unsigned 0xFFFFFFFF/1 -> o_quot=0xFFFFFFFF, o_rem=0;
  - i_start pulsed during CALC with new operands -> no effect;
  - i_start held in DONE -> second operation accepted with no IDLE cycle.
- Reset mid-operation: rst_n=0 during CALC iteration 10 -> all outputs 0 immediately, no o_valid pulse. A following 9/3 -> o_quot=3, o_rem=0.

Source files
------------

// File: rtl/div_32.sv
// =============================================================================
//  Module   : div_32
//  Purpose  : 32-bit restoring divider (RV32M DIV/DIVU/REM/REMU), one bit/cycle
//  Revision : 1.0
// =============================================================================
`default_nettype none

module div_32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_signed,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_quot,
    output logic [31:0] o_rem,
    output logic        o_busy,
    output logic        o_valid
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q,   cnt_d;
    logic [31:0] dvd_q,   dvd_d;
    logic [31:0] dvs_q,   dvs_d;
    logic [31:0] prem_q,  prem_d;
    logic        negq_q,  negq_d;
    logic        negr_q,  negr_d;
    logic [31:0] quot_q,  quot_d;
    logic [31:0] rem_q,   rem_d;

    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic        w_ovf;
    logic [32:0] w_trial;
    logic [32:0] w_sum;
    logic        w_carry;

    assign w_abs_a = (i_signed && i_a[31]) ? (~i_a + 32'd1) : i_a;
    assign w_abs_b = (i_signed && i_b[31]) ? (~i_b + 32'd1) : i_b;
    assign w_ovf   = i_signed && (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

    // The divisor's bit 32 is zero, so the top stage of the carry chain reduces
    // to trial[32] OR the carry out of the lower 32 bits.
    assign w_trial = {prem_q, dvd_q[31]};
    assign w_sum   = {1'b0, w_trial[31:0]} + {1'b0, ~dvs_q} + 33'd1;
    assign w_carry = w_trial[32] | w_sum[32];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (i_start) begin
                    cnt_d  = 5'd0;
                    dvd_d  = w_abs_a;
                    dvs_d  = w_abs_b;
                    prem_d = 32'd0;
                    negq_d = i_signed & (i_a[31] ^ i_b[31]);
                    negr_d = i_signed & i_a[31];
                    if (i_b == 32'd0) begin
                        state_d = DONE;
                        quot_d  = 32'hFFFF_FFFF;
                        rem_d   = i_a;
                    end else if (w_ovf) begin
                        state_d = DONE;
                        quot_d  = 32'h8000_0000;
                        rem_d   = 32'd0;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                cnt_d  = cnt_q + 5'd1;
                dvd_d  = {dvd_q[30:0], w_carry};
                prem_d = w_carry ? w_sum[31:0] : w_trial[31:0];
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quot_d  = negq_q ? (~dvd_q + 32'd1) : dvd_q;
                rem_d   = negr_q ? (~prem_q + 32'd1) : prem_q;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            dvd_q   <= 32'd0;
            dvs_q   <= 32'd0;
            prem_q  <= 32'd0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            quot_q  <= 32'd0;
            rem_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign o_quot  = quot_q;
    assign o_rem   = rem_q;
    assign o_busy  = (state_q == CALC) || (state_q == FIX);
    assign o_valid = (state_q == DONE);

endmodule

`default_nettype wire
